// File: rtl/vp_pkg.sv
// vp_pkg -- shared definitions for the pipeline hazard controller.
//   vp_state_e : vector-access FSM states (ST_RUN, ST_VMEM)
//   FWD_*      : operand forward-select encodings
//   VP_BEATS   : default number of memory beats per vector access
//   vbeat_w()  : width of the beat counter for a given beat count
package vp_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_VMEM = 1'b1
    } vp_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int VP_BEATS = 4;

    // A single-beat access still needs a 1-bit counter so the port exists.
    function automatic int vbeat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit -- operand forwarding select for one Execute source operand.
//   src      : source register index of the operand in Execute
//   dst_m    : destination index in Memory,    regw_m : its write enable
//   dst_w    : destination index in Writeback, regw_w : its write enable
//   fwd_sel  : FWD_MEM / FWD_WB / FWD_RF
// Register 0 is hard-wired, so it is never forwarded. Memory is the
// younger result and therefore wins over Writeback.
module fwd_unit
    import vp_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] src,
    input  logic [M-1:0] dst_m,
    input  logic         regw_m,
    input  logic [M-1:0] dst_w,
    input  logic         regw_w,
    output logic [1:0]   fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (src != '0) begin
            if (regw_m && (dst_m == src)) begin
                fwd_sel = FWD_MEM;
            end else if (regw_w && (dst_w == src)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit: load-use stall, branch flush,
// operand forwarding and sequencing of multi-beat vector memory accesses.
//   clk, rst               : clock, asynchronous active-low reset
//   regAD/regBD            : Decode source indices
//   regAE/regBE            : Execute source indices
//   regScr_E/M/W, regw_E/M/W : destination index / write enable per stage
//   regmem_E               : Execute instruction is a load
//   branch_taken_E         : taken branch resolved in Execute
//   vmem_E, mem_ready      : vector memory op in Execute, memory beat accepted
//   stall_F/D/E, flush_D/E : pipeline control
//   fwdA_E, fwdB_E         : forward selects for Execute operands
//   vbeat, busy            : registered beat index / access in progress
//   vmem_done              : combinational pulse on the final beat
//   dbg_state              : current FSM state, for observation
//
// Handshake: a beat transfers in any cycle where vmem_E and mem_ready are
// both high; mem_ready low simply holds the beat index and FSM state while
// the pipeline stays stalled.
module hazard_ctrl
    import vp_pkg::*;
#(
    parameter int M     = 4,
    parameter int BEATS = VP_BEATS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [M-1:0]                regAD,
    input  logic [M-1:0]                regBD,
    input  logic [M-1:0]                regAE,
    input  logic [M-1:0]                regBE,
    input  logic [M-1:0]                regScr_E,
    input  logic [M-1:0]                regScr_M,
    input  logic [M-1:0]                regScr_W,
    input  logic                        regw_E,
    input  logic                        regw_M,
    input  logic                        regw_W,
    input  logic                        regmem_E,
    input  logic                        branch_taken_E,
    input  logic                        vmem_E,
    input  logic                        mem_ready,
    output logic                        stall_F,
    output logic                        stall_D,
    output logic                        stall_E,
    output logic                        flush_D,
    output logic                        flush_E,
    output logic [1:0]                  fwdA_E,
    output logic [1:0]                  fwdB_E,
    output logic [vbeat_w(BEATS)-1:0]   vbeat,
    output logic                        vmem_done,
    output logic                        busy,
    output vp_state_e                   dbg_state
);

    localparam int VBW = vbeat_w(BEATS);
    localparam logic [VBW-1:0] LAST_BEAT = VBW'(BEATS - 1);

    vp_state_e      state_q, state_d;
    logic [VBW-1:0] vbeat_q, vbeat_d;

    logic last;
    logic beat_go;
    logic vmem_stall;
    logic branch_ok;
    logic load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // Hazard conditions. While a vector access is stalling the pipe, the
    // instruction in Execute is frozen, so neither a branch nor a load-use
    // can be acted on yet.
    always_comb begin
        beat_go    = vmem_E && mem_ready;
        last       = beat_go && (vbeat_q == LAST_BEAT);
        vmem_stall = vmem_E && !last;
        branch_ok  = branch_taken_E && !vmem_stall;
        load_use   = !vmem_stall && regmem_E && regw_E && (regScr_E != '0) &&
                     ((regScr_E == regAD) || (regScr_E == regBD));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            vbeat_q <= '0;
        end else begin
            state_q <= state_d;
            vbeat_q <= vbeat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        vbeat_d = vbeat_q;
        case (state_q)
            ST_RUN: begin
                // A single-beat access completes here and never leaves RUN.
                if (beat_go && !last) begin
                    state_d = ST_VMEM;
                end
            end
            ST_VMEM: begin
                if (last) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (last) begin
            vbeat_d = '0;
        end else if (beat_go) begin
            vbeat_d = vbeat_q + VBW'(1);
        end
    end

    fwd_unit #(.M(M)) u_fwd_a (
        .src     (regAE),
        .dst_m   (regScr_M),
        .regw_m  (regw_M),
        .dst_w   (regScr_W),
        .regw_w  (regw_W),
        .fwd_sel (fwd_a_raw)
    );

    fwd_unit #(.M(M)) u_fwd_b (
        .src     (regBE),
        .dst_m   (regScr_M),
        .regw_m  (regw_M),
        .dst_w   (regScr_W),
        .regw_w  (regw_W),
        .fwd_sel (fwd_b_raw)
    );

    // Output logic. During reset the pipeline registers are flushed and
    // everything else is held quiet.
    always_comb begin
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        stall_E   = 1'b0;
        flush_D   = 1'b1;
        flush_E   = 1'b1;
        fwdA_E    = FWD_RF;
        fwdB_E    = FWD_RF;
        vmem_done = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            // Branch wins over load-use: the stalled Decode instruction is
            // on the wrong path anyway, so it is flushed instead of held.
            stall_F   = vmem_stall || (load_use && !branch_ok);
            stall_D   = vmem_stall || (load_use && !branch_ok);
            stall_E   = vmem_stall;
            flush_D   = branch_ok;
            flush_E   = branch_ok || load_use;
            fwdA_E    = fwd_a_raw;
            fwdB_E    = fwd_b_raw;
            vmem_done = last;
            busy      = (state_q == ST_VMEM);
        end
        vbeat     = vbeat_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import vp_pkg::*;

    localparam int M     = 4;
    localparam int BEATS = 4;
    localparam int W     = 14;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [M-1:0] regAD, regBD, regAE, regBE;
    logic [M-1:0] regScr_E, regScr_M, regScr_W;
    logic regw_E, regw_M, regw_W, regmem_E, branch_taken_E, vmem_E, mem_ready;
    logic stall_F, stall_D, stall_E, flush_D, flush_E, vmem_done, busy;
    logic [1:0] fwdA_E, fwdB_E;
    logic [1:0] vbeat;
    vp_state_e dbg_state;

    hazard_ctrl #(.M(M), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .regAD(regAD), .regBD(regBD), .regAE(regAE), .regBE(regBE),
        .regScr_E(regScr_E), .regScr_M(regScr_M), .regScr_W(regScr_W),
        .regw_E(regw_E), .regw_M(regw_M), .regw_W(regw_W),
        .regmem_E(regmem_E), .branch_taken_E(branch_taken_E),
        .vmem_E(vmem_E), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_D(flush_D), .flush_E(flush_E),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .vbeat(vbeat), .vmem_done(vmem_done), .busy(busy),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: number of beats already transferred in the current
    // vector access (0 when none is in flight).
    int m_beat = 0;

    function automatic logic [1:0] ref_fwd(input logic [M-1:0] src);
        if (src != 0 && regw_M && regScr_M == src) return 2'b10;
        if (src != 0 && regw_W && regScr_W == src) return 2'b01;
        return 2'b00;
    endfunction

    // Output packing: {state, busy, done, vbeat, fwdB, fwdA, fE, fD, sE, sD, sF}
    task automatic tick(input string nm);
        logic [W-1:0] e;
        bit last, vstall, br, lu, in_acc;
        if (!rst) m_beat = 0;
        in_acc = (m_beat != 0);
        last   = vmem_E && mem_ready && (m_beat == BEATS - 1);
        vstall = vmem_E && !last;
        br     = branch_taken_E && !vstall;
        lu     = !vstall && regmem_E && regw_E && regScr_E != 0 &&
                 (regScr_E == regAD || regScr_E == regBD);
        if (!rst)
            e = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        else
            e = {in_acc, in_acc, last, 2'(m_beat), ref_fwd(regBE), ref_fwd(regAE),
                 br || lu, br, vstall, vstall || (lu && !br), vstall || (lu && !br)};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        if (!rst) m_beat = 0;
        else if (vmem_E && mem_ready) m_beat = (m_beat + 1) % BEATS;
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] e, act;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {logic'(dbg_state), busy, vmem_done, vbeat, fwdB_E, fwdA_E,
                   flush_E, flush_D, stall_E, stall_D, stall_F};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s @%0t: actual=%b required=%b (state,busy,done,vbeat,fwdB,fwdA,fE,fD,sE,sD,sF)",
                         nm, $time, act, e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle();
        regAD = 0; regBD = 0; regAE = 0; regBE = 0;
        regScr_E = 0; regScr_M = 0; regScr_W = 0;
        regw_E = 0; regw_M = 0; regw_W = 0;
        regmem_E = 0; branch_taken_E = 0; vmem_E = 0; mem_ready = 0;
    endtask

    initial begin : stim
        bit rdy_pat[5];
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Reset: forwarding candidates present but must be masked.
        regAE = 5; regScr_M = 5; regw_M = 1;
        vmem_E = 1; mem_ready = 1;
        tick("reset_a");
        tick("reset_b");
        idle();
        rst = 1'b1;
        tick("idle");

        // Load-use
        regmem_E = 1; regw_E = 1; regScr_E = 3; regAD = 3;
        tick("load_use_a");
        regAD = 0; regBD = 3;
        tick("load_use_b");
        regScr_E = 0; regAD = 0; regBD = 0;
        tick("load_use_r0");
        regmem_E = 0; regScr_E = 3; regAD = 3;
        tick("no_load");
        idle();

        // Forwarding
        regAE = 5; regBE = 5; regScr_M = 5; regw_M = 1; regScr_W = 5; regw_W = 1;
        tick("fwd_mem");
        regw_M = 0;
        tick("fwd_wb");
        regAE = 0; regBE = 0;
        tick("fwd_r0");
        idle();

        // Vector access with back-pressure on the second beat
        rdy_pat = '{1, 0, 1, 1, 1};
        vmem_E = 1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy_pat[i];
            tick($sformatf("vmem_bp_%0d", i));
        end
        idle();
        tick("vmem_after");

        // Branch together with load-use
        branch_taken_E = 1; regmem_E = 1; regw_E = 1; regScr_E = 3; regAD = 3;
        tick("branch_lu");
        idle();

        // Branch during a vector stall, then on the final beat
        vmem_E = 1; mem_ready = 1; branch_taken_E = 1;
        for (int i = 0; i < BEATS; i++) tick($sformatf("vmem_branch_%0d", i));
        idle();
        tick("branch_clear");

        // Reset in the middle of an access
        vmem_E = 1; mem_ready = 1;
        tick("rst_mid_0");
        tick("rst_mid_1");
        rst = 1'b0;
        tick("rst_mid_low_a");
        tick("rst_mid_low_b");
        rst = 1'b1;
        for (int i = 0; i < BEATS; i++) tick($sformatf("rst_restart_%0d", i));
        idle();
        tick("restart_done");

        // Randomized traffic; small index range makes matches frequent.
        for (int n = 0; n < 3000; n++) begin
            regAD    = M'($urandom_range(0, 3));
            regBD    = M'($urandom_range(0, 3));
            regAE    = M'($urandom_range(0, 3));
            regBE    = M'($urandom_range(0, 3));
            regScr_E = M'($urandom_range(0, 3));
            regScr_M = M'($urandom_range(0, 3));
            regScr_W = M'($urandom_range(0, 3));
            regw_E   = 1'($urandom_range(0, 1));
            regw_M   = 1'($urandom_range(0, 1));
            regw_W   = 1'($urandom_range(0, 1));
            regmem_E = 1'($urandom_range(0, 1));
            branch_taken_E = ($urandom_range(0, 3) == 0);
            vmem_E    = (m_beat != 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) != 0);
            tick("random");
        end
        idle();
        rst = 1'b1;
        tick("final_idle");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter M, default 4: register-index width.
REQ-002 SHALL have parameter BEATS, default 4: memory beats per vector access (V/N).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports regAD, regBD, input, M each: source register indices in Decode.
REQ-006 SHALL have ports regAE, regBE, input, M each: source register indices in Execute.
REQ-007 SHALL have ports regScr_E, regScr_M, regScr_W, input, M each: destination register index per stage.
REQ-008 SHALL have ports regw_E, regw_M, regw_W, input, 1 each: register-write enable per stage.
REQ-009 SHALL have port regmem_E, input, 1: Execute instruction is a load.
REQ-010 SHALL have port branch_taken_E, input, 1: resolved taken branch in Execute.
REQ-011 SHALL have port vmem_E, input, 1: vector memory instruction in Execute.
REQ-012 SHALL have port mem_ready, input, 1: memory accepts the current beat.
REQ-013 SHALL have ports stall_F, stall_D, stall_E, output, 1 each: hold the PC, F/D and D/E registers.
REQ-014 SHALL have ports flush_D, flush_E, output, 1 each: clear the F/D and D/E registers.
REQ-015 SHALL have ports fwdA_E, fwdB_E, output, 2 each: operand forward select (00 = register file, 01 = Writeback, 10 = Memory).
REQ-016 SHALL have port vbeat, output, clog2(BEATS): current vector beat index.
REQ-017 SHALL have ports vmem_done, output, 1, and busy, output, 1.

Function
REQ-018 SHALL define "last" = vmem_E && mem_ready && vbeat==BEATS-1.
REQ-019 SHALL be an FSM with states RUN and VMEM.
- RUN -> VMEM: on vmem_E && mem_ready && !last.
- VMEM -> RUN: on last.
- RUN with BEATS==1 and last: stays in RUN.
REQ-020 SHALL increment vbeat on vmem_E && mem_ready, wrap it to 0 on last, and hold it otherwise.
REQ-021 SHALL pulse vmem_done combinationally for exactly the cycle in which last is true.
REQ-022 SHALL assert busy whenever state==VMEM.
REQ-023 SHALL assert stall_F=stall_D=stall_E whenever vmem_E && !last, and hold the FSM state while mem_ready is low.
REQ-024 SHALL detect load-use, only when no vmem stall is active: regmem_E && regw_E && regScr_E!=0 && (regScr_E==regAD || regScr_E==regBD).
- On load-use: stall_F=stall_D=1 and flush_E=1 for that cycle.
REQ-025 SHALL assert flush_D=flush_E=1 on branch_taken_E, with priority over load-use, and shall suppress stall_F/stall_D in that cycle.
REQ-026 SHALL ignore branch_taken_E while the vmem stall of REQ-023 is active.
REQ-027 SHALL generate forwarding combinationally.
- fwdA_E=10 if regw_M && regScr_M==regAE && regAE!=0.
- Else fwdA_E=01 if regw_W && regScr_W==regAE && regAE!=0.
- Else fwdA_E=00.
- Memory has priority over Writeback. fwdB_E is identical, using regBE.
REQ-028 SHALL produce all outputs with zero-cycle latency from inputs, except vbeat and busy, which are registered.

Reset
REQ-029 SHALL, while rst=0, force state=RUN and vbeat=0.
REQ-030 SHALL, while rst=0, force busy=0, vmem_done=0, all stalls=0, fwdA_E=fwdB_E=00, and flush_D=flush_E=1.
REQ-031 SHALL abandon an in-progress vector access if reset asserts mid-access; the first cycle after reset release is RUN with beat 0.

Structure
REQ-032 SHALL take the FSM state enum, the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the default BEATS from a shared package, vp_pkg.
REQ-033 SHALL instantiate one sub-module, fwd_unit, used twice (operands A and B), to implement REQ-027.

Verification
REQ-034 SHALL cover load-use: regmem_E=1, regw_E=1, regScr_E=3, regAD=3 -> stall_F=stall_D=flush_E=1 for one cycle; regScr_E=0 -> no stall.
REQ-035 SHALL cover forwarding: regAE=5, regScr_M=5, regw_M=1, regScr_W=5, regw_W=1 -> fwdA_E=10; with regw_M=0 -> fwdA_E=01.
REQ-036 SHALL cover a vector access with back-pressure: vmem_E=1, BEATS=4, mem_ready low on the 2nd beat -> vbeat 0,1,1,2,3; stalls high for 4 cycles; vmem_done pulses in the 5th cycle; busy low in the 6th.
REQ-037 SHALL cover simultaneous events: branch_taken_E and load-use in the same cycle -> flush_D=flush_E=1, stalls=0; branch_taken_E during a vmem stall -> no flush.
REQ-038 SHALL cover reset mid-access: rst low at vbeat=2 -> state RUN, vbeat=0, flush_D=flush_E=1 while low; vmem_E=1 after release restarts at beat 0.
